writeback_queue: RTL

Small in-order FIFO between the ALU/memory completion paths and the register file write port. It accepts up to two results per cycle and drains one per cycle into the register file. It also provides youngest-match forwarding of queued values to the decode-stage read selects. This makes the queue the producing end of the register file write protocol (WEN, wsel, wdat).

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/writeback_queue_if.sv | 55 +++++
 rtl/wb_fwd_match.sv | 38 +++
 rtl/writeback_queue.sv | 96 +++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t     : 32-bit architectural data word
//   regbits_t  : 5-bit register select
//   wb_entry_t : one pending register-file write {wsel, wdat}
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef struct packed {
    regbits_t wsel;
    word_t    wdat;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Bundle of signals between the completion paths / decode stage and the
// writeback queue.
//   producer side : mem_valid/mem_wsel/mem_wdat, alu_valid/alu_wsel/alu_wdat, in_ready
//   write port    : WEN, wsel, wdat (queue drives the register file)
//   forwarding    : rsel1/rsel2 in, fwd1_hit/fwd1_dat, fwd2_hit/fwd2_dat out
//   status        : count (occupied entries)
// modport slave  : the queue itself
// modport master : the surrounding pipeline
interface writeback_queue_if
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             mem_valid;
  regbits_t         mem_wsel;
  word_t            mem_wdat;
  logic             alu_valid;
  regbits_t         alu_wsel;
  word_t            alu_wdat;
  logic             in_ready;

  logic             WEN;
  regbits_t         wsel;
  word_t            wdat;

  regbits_t         rsel1;
  regbits_t         rsel2;
  logic             fwd1_hit;
  logic             fwd2_hit;
  word_t            fwd1_dat;
  word_t            fwd2_dat;

  logic [CNT_W-1:0] count;

  modport slave (
    input  mem_valid, mem_wsel, mem_wdat,
    input  alu_valid, alu_wsel, alu_wdat,
    input  rsel1, rsel2,
    output in_ready, WEN, wsel, wdat,
    output fwd1_hit, fwd1_dat, fwd2_hit, fwd2_dat,
    output count
  );

  modport master (
    output mem_valid, mem_wsel, mem_wdat,
    output alu_valid, alu_wsel, alu_wdat,
    output rsel1, rsel2,
    input  in_ready, WEN, wsel, wdat,
    input  fwd1_hit, fwd1_dat, fwd2_hit, fwd2_dat,
    input  count
  );

endinterface

// File: rtl/wb_fwd_match.sv
// Youngest-match search of the writeback queue for one decode read select.
//   entries : entry array, indexed by physical slot
//   head    : slot of the oldest occupied entry
//   count   : number of occupied entries (slots head .. head+count-1)
//   rsel    : register being read; 0 never matches
//   hit/dat : a queued entry targets rsel, and the youngest such value
module wb_fwd_match
  import cpu_types_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]      head,
  input  logic [CNT_W-1:0]      count,
  input  regbits_t              rsel,
  output logic                  hit,
  output word_t                 dat
);

  // NOTE: every output gets a default before the loop, so no path through
  // this block leaves a value held and no latch is inferred.
  always_comb begin
    hit = 1'b0;
    dat = '0;
    // Walk from oldest to youngest; a later match overwrites an earlier
    // one, so the youngest matching entry is what remains.
    for (int i = 0; i < DEPTH; i++) begin
      if ((rsel != '0) && (CNT_W'(i) < count) &&
          (entries[head + PTR_W'(i)].wsel == rsel)) begin
        hit = 1'b1;
        dat = entries[head + PTR_W'(i)].wdat;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback FIFO between the memory/ALU completion paths and the
// register file write port. Accepts up to two results per cycle (mem is the
// older and lands first), drains one per cycle, and forwards the youngest
// queued value for each decode read select.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset; discards all pending entries
//   wbif : writeback_queue_if.slave (producer, write port, forwarding, count)
module writeback_queue
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               CLK,
  input logic               nRST,
  writeback_queue_if.slave  wbif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic                  in_ready;
  logic                  mem_acc;
  logic                  alu_acc;
  logic [1:0]            n_push;
  logic                  pop;
  logic [PTR_W-1:0]      alu_slot;

  // Space for two is required regardless of which sources are valid, and
  // the same-cycle retirement is deliberately not credited.
  assign in_ready = (count <= CNT_W'(DEPTH - 2));

  // Results targeting r0 have no architectural effect and are dropped.
  assign mem_acc  = wbif.mem_valid && in_ready && (wbif.mem_wsel != '0);
  assign alu_acc  = wbif.alu_valid && in_ready && (wbif.alu_wsel != '0);
  assign n_push   = 2'(mem_acc) + 2'(alu_acc);
  assign pop      = (count != '0);

  // ALU goes directly behind the memory result when both are accepted,
  // otherwise it takes the tail slot itself.
  assign alu_slot = tail + PTR_W'(mem_acc);

  // NOTE: state registers use non-blocking assignments so every update in
  // this block sees the pre-edge values of head/tail/count.
  // NOTE: the entry array is reset as well as the pointers; the write port
  // and forwarding then present zeros out of reset rather than stale data.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      entries <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (mem_acc) begin
        entries[tail] <= '{wsel: wbif.mem_wsel, wdat: wbif.mem_wdat};
      end
      if (alu_acc) begin
        entries[alu_slot] <= '{wsel: wbif.alu_wsel, wdat: wbif.alu_wdat};
      end
      tail  <= tail + PTR_W'(n_push);
      head  <= head + PTR_W'(pop);
      count <= count + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

  // Register file write port: no backpressure, head retires every cycle
  // the queue is non-empty.
  assign wbif.WEN      = pop;
  assign wbif.wsel     = entries[head].wsel;
  assign wbif.wdat     = entries[head].wdat;
  assign wbif.in_ready = in_ready;
  assign wbif.count    = count;

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (entries),
    .head    (head),
    .count   (count),
    .rsel    (wbif.rsel1),
    .hit     (wbif.fwd1_hit),
    .dat     (wbif.fwd1_dat)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (entries),
    .head    (head),
    .count   (count),
    .rsel    (wbif.rsel2),
    .hit     (wbif.fwd2_hit),
    .dat     (wbif.fwd2_dat)
  );

endmodule
